demux_shkrimi: RTL and testbench
================================

# demux_shkrimi

Write-back demultiplexer and register bank for the 16-bit CPU: the destination-side counterpart of the result-select multiplexer. One result word per cycle enters with a 3-bit destination select and is routed into one of eight destination registers through a single pending (commit) stage. Two read ports see committed contents, with forwarding from the pending stage. Sits between the ALU result mux and the operand fetch path.

## Interface
- WIDTH, 16, data word width
- NREG, 8, number of destination registers; select width fixed at 3 bits
- Clock  in  1  single clock, all state updates on rising edge
- Reset_n  in  1  synchronous, active-low reset, sampled on rising edge of Clock
- wr_valid  in  1  write request present
- wr_ready  out  1  block can accept a request this cycle
- wr_sel  in  3  destination register index, 0..7
- wr_data  in  WIDTH  word to write
- stall  in  1  freeze commit stage; no commit, no accept
- rd_sel_a  in  3  read port A index
- rd_data_a  out  WIDTH  read port A data (combinational)
- rd_sel_b  in  3  read port B index
- rd_data_b  out  WIDTH  read port B data (combinational)
- wr_count  out  8  number of committed writes to registers 1..7, modulo 256

## Operation
- Register 0 reads as 0 always; writes to index 0 are accepted (handshake completes) but never commit and never forward.
- Accept: wr_valid && wr_ready at a rising edge, and Reset_n=1 at that edge; captures {wr_sel, wr_data} into pending stage, p_valid <= 1.
- wr_ready = !stall. Not dependent on p_valid; pending stage drains every non-stalled cycle, so full throughput of one write per cycle.
- Commit: on each edge with stall=0 and p_valid=1, reg[p_sel] <= p_data if p_sel != 0; wr_count increments on that commit (p_sel != 0 only), wraps 255 -> 0.
- Same edge: commit of old pending entry and capture of new request both occur; p_valid <= 1 if new accept, else 0.
- stall=1: pending entry, registers and wr_count hold; wr_ready=0 so no accept; wr_valid ignored.
- Read port (each independent): if sel==0 -> 0; else if p_valid && p_sel==sel -> p_data (forward); else reg[sel].
- Both read ports may address the same register; both return identical data.
- Back-to-back writes to same index: later value wins in both array and forwarding.

## Timing
- Reset (Reset_n=0 at edge): all reg[1..7] <= 0, p_valid <= 0, wr_count <= 0. Outputs after reset edge: rd_data_a=rd_data_b=0, wr_count=0, wr_ready=!stall (combinational; reset does not force it).
- Reset overrides everything, including stall and a simultaneous accept; an in-flight pending entry is discarded, not committed.
- Request accepted at edge N: forwarded on read ports during cycle N..N+1 (from after edge N); written into array at edge N+1 (if not stalled); visible unchanged from then on.
- Read latency: 0 cycles (combinational from rd_sel and state).
- Stall at edge N+1: commit deferred to first subsequent edge with stall=0; forwarding continues to present pending data throughout the stall.
- wr_count updates on the same edge as the commit it counts.

## Test plan
- Reset: drive Reset_n=0 one edge with stall=0, wr_valid=1, wr_sel=3, wr_data=16'hFFFF -> after edge p_valid=0, rd_data_a(sel 3)=0, wr_count=0; next cycles reg 3 stays 0.
- Basic write/forward: accept sel=5, data=16'hA5A5 at edge N -> rd_data_a(sel 5)=16'hA5A5 immediately after edge N (forwarded) and after edge N+1 (array); wr_count=1 after N+1.
- Register 0: accept sel=0, data=16'h1234 -> wr_ready=1, rd_data_b(sel 0)=0 at all times, wr_count unchanged.
- Back-to-back same index: accept sel=2 data 16'h0001 at N, sel=2 data 16'h0002 at N+1 -> port A on sel 2 reads 0001 after N, 0002 after N+1 and thereafter; wr_count=2 after N+2.
- Stall: accept sel=7 data 16'hBEEF at N, stall=1 for edges N+1..N+3 with wr_valid=1 sel=6 -> wr_ready=0, reg 6 unchanged, sel 7 forwards BEEF, wr_count held; stall=0 at N+4 -> BEEF committed, wr_count +1.
- Counter wrap: 256 consecutive commits to sel=1 with incrementing data -> wr_count returns to 0, reg 1 holds last data value.

Source files
------------

// File: rtl/demux_shkrimi.sv
// -----------------------------------------------------------------------------
// demux_shkrimi
//
// Write-back demultiplexer and register bank for the 16-bit CPU. One result
// word per cycle enters with a 3-bit destination select, is held for one
// cycle in a pending (commit) stage and is then written into one of eight
// destination registers. Two combinational read ports see committed contents,
// with forwarding from the pending stage so a freshly accepted write is
// visible immediately.
//
// Ports:
//   Clock      in   single clock, all state updates on rising edge
//   Reset_n    in   synchronous active-low reset
//   wr_valid   in   write request present
//   wr_ready   out  request can be accepted this cycle (= !stall)
//   wr_sel     in   destination register index 0..7
//   wr_data    in   word to write
//   stall      in   freeze commit stage; no commit, no accept
//   rd_sel_a   in   read port A index
//   rd_data_a  out  read port A data (combinational)
//   rd_sel_b   in   read port B index
//   rd_data_b  out  read port B data (combinational)
//   wr_count   out  committed writes to registers 1..7, modulo 256
//
// Handshake: a request transfers on a rising edge where wr_valid && wr_ready
// are both high and Reset_n is high. wr_ready depends only on stall, never on
// wr_valid or on pending occupancy, because the pending stage drains on every
// non-stalled edge in the same cycle it refills.
// -----------------------------------------------------------------------------
module demux_shkrimi #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8   // select is fixed at 3 bits, so this must be 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             stall,
  input  logic [2:0]       rd_sel_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [2:0]       rd_sel_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [7:0]       wr_count
);

  // Entry 0 exists only to keep indexing uniform; it is never written after
  // reset and the read ports bypass it anyway.
  logic [WIDTH-1:0] r_regs [0:NREG-1];

  // Pending (commit) stage
  logic             r_p_valid;
  logic [2:0]       r_p_sel;
  logic [WIDTH-1:0] r_p_data;

  logic [7:0]       r_wr_count;

  logic             w_commit;
  logic             w_fwd_a;
  logic             w_fwd_b;

  // A pending write to index 0 drains like any other entry but leaves no trace.
  assign w_commit = r_p_valid && (r_p_sel != 3'd0);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      // Reset wins over stall and over a same-edge accept; any pending entry
      // is dropped without committing.
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_p_valid  <= 1'b0;
      r_p_sel    <= 3'd0;
      r_p_data   <= '0;
      r_wr_count <= 8'd0;
    end else if (!stall) begin
      if (w_commit) begin
        r_regs[r_p_sel] <= r_p_data;
        r_wr_count      <= r_wr_count + 8'd1;
      end
      // Old entry commits and new request is captured on the same edge.
      r_p_valid <= wr_valid;
      r_p_sel   <= wr_sel;
      r_p_data  <= wr_data;
    end
  end

  assign wr_ready = !stall;
  assign wr_count = r_wr_count;

  // Forwarding is gated by sel != 0 through the first branch of the read mux,
  // so a pending write to index 0 never shows up on a read port.
  assign w_fwd_a = r_p_valid && (r_p_sel == rd_sel_a);
  assign w_fwd_b = r_p_valid && (r_p_sel == rd_sel_b);

  assign rd_data_a = (rd_sel_a == 3'd0) ? '0 :
                     w_fwd_a            ? r_p_data : r_regs[rd_sel_a];
  assign rd_data_b = (rd_sel_b == 3'd0) ? '0 :
                     w_fwd_b            ? r_p_data : r_regs[rd_sel_b];

endmodule

// File: tb/tb_demux_shkrimi.sv
// -----------------------------------------------------------------------------
// tb_demux_shkrimi
//
// Directed scenarios with hand-computed expectations, followed by a random
// phase. A behavioural model (register array, queue of not-yet-committed
// writes, unbounded commit counter) tracks what the block must hold; one
// compare process checks every output against it on each falling edge.
// Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_demux_shkrimi;

  localparam int WIDTH = 16;

  // ---------------------------------------------------------------- clock/reset
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic             Reset_n;
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             stall;
  logic [2:0]       rd_sel_a;
  logic [WIDTH-1:0] rd_data_a;
  logic [2:0]       rd_sel_b;
  logic [WIDTH-1:0] rd_data_b;
  logic [7:0]       wr_count;

  demux_shkrimi #(.WIDTH(WIDTH), .NREG(8)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .stall     (stall),
    .rd_sel_a  (rd_sel_a),
    .rd_data_a (rd_data_a),
    .rd_sel_b  (rd_sel_b),
    .rd_data_b (rd_data_b),
    .wr_count  (wr_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic [WIDTH-1:0] m_regs [8];
  wr_t              pend_q[$];     // accepted but not yet committed writes
  int               m_commits = 0; // unbounded count of commits to 1..7
  bit               m_live = 1'b0; // model meaningful once a reset edge seen
  logic [WIDTH-1:0] exp_q[$];      // literal expectations for directed checks

  function automatic logic [WIDTH-1:0] model_read(input logic [2:0] sel);
    if (sel == 3'd0) return '0;
    for (int i = pend_q.size() - 1; i >= 0; i--) begin
      if (pend_q[i].sel == sel) return pend_q[i].data;
    end
    return m_regs[sel];
  endfunction

  always @(posedge Clock) begin
    if (Reset_n === 1'b0) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      pend_q.delete();
      m_commits = 0;
      m_live = 1'b1;
    end else if (m_live && !stall) begin
      if (pend_q.size() > 0) begin
        wr_t w;
        w = pend_q.pop_front();
        if (w.sel != 3'd0) begin
          m_regs[w.sel] = w.data;
          m_commits++;
        end
      end
      if (wr_valid) pend_q.push_back(wr_t'({wr_sel, wr_data}));
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge Clock) begin
    if (m_live) begin
      check("wr_ready",  {31'd0, wr_ready}, {31'd0, !stall});
      check("rd_data_a", {16'd0, rd_data_a}, {16'd0, model_read(rd_sel_a)});
      check("rd_data_b", {16'd0, rd_data_b}, {16'd0, model_read(rd_sel_b)});
      check("wr_count",  {24'd0, wr_count}, m_commits % 256);
    end
  end

  // ---------------------------------------------------------------- driver
  // Apply inputs for one rising edge, return 1 time unit after it.
  task automatic drive(input logic rst_n, input logic v, input logic [2:0] s,
                       input logic [WIDTH-1:0] d, input logic st);
    Reset_n  = rst_n;
    wr_valid = v;
    wr_sel   = s;
    wr_data  = d;
    stall    = st;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    Reset_n = 1'b0; wr_valid = 1'b1; wr_sel = 3'd3; wr_data = 16'hFFFF;
    stall = 1'b0; rd_sel_a = 3'd3; rd_sel_b = 3'd0;

    // Reset with a simultaneous request: nothing captured.
    drive(1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b0);
    check("rst_rd_a", {16'd0, rd_data_a}, 32'h0);
    check("rst_count", {24'd0, wr_count}, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    check("rst_reg3_stays0", {16'd0, rd_data_a}, 32'h0);

    // Basic write / forward.
    rd_sel_a = 3'd5;
    drive(1'b1, 1'b1, 3'd5, 16'hA5A5, 1'b0);
    check("fwd_a5a5", {16'd0, rd_data_a}, 32'hA5A5);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    check("arr_a5a5", {16'd0, rd_data_a}, 32'hA5A5);
    check("count_1", {24'd0, wr_count}, 32'd1);

    // Register 0: handshake completes, nothing stored or forwarded.
    rd_sel_b = 3'd0;
    wr_valid = 1'b1; wr_sel = 3'd0; wr_data = 16'h1234; stall = 1'b0;
    #1;
    check("reg0_ready", {31'd0, wr_ready}, 32'd1);
    drive(1'b1, 1'b1, 3'd0, 16'h1234, 1'b0);
    check("reg0_rd_pend", {16'd0, rd_data_b}, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    check("reg0_rd_after", {16'd0, rd_data_b}, 32'h0);
    check("reg0_count", {24'd0, wr_count}, 32'd1);

    // Back-to-back writes to the same index.
    rd_sel_a = 3'd2;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0002);
    drive(1'b1, 1'b1, 3'd2, 16'h0001, 1'b0);
    check("b2b_first", {16'd0, rd_data_a}, {16'd0, exp_q.pop_front()});
    drive(1'b1, 1'b1, 3'd2, 16'h0002, 1'b0);
    check("b2b_second", {16'd0, rd_data_a}, {16'd0, exp_q.pop_front()});
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    check("b2b_final", {16'd0, rd_data_a}, {16'd0, exp_q.pop_front()});
    check("b2b_count", {24'd0, wr_count}, 32'd3);

    // Stall holds the pending entry, registers and counter.
    rd_sel_a = 3'd7; rd_sel_b = 3'd6;
    drive(1'b1, 1'b1, 3'd7, 16'hBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 3'd6, 16'h1111, 1'b1);
      check("stall_ready", {31'd0, wr_ready}, 32'd0);
      check("stall_fwd", {16'd0, rd_data_a}, 32'hBEEF);
      check("stall_reg6", {16'd0, rd_data_b}, 32'h0);
      check("stall_count", {24'd0, wr_count}, 32'd3);
    end
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    check("unstall_data", {16'd0, rd_data_a}, 32'hBEEF);
    check("unstall_count", {24'd0, wr_count}, 32'd4);
    check("unstall_reg6", {16'd0, rd_data_b}, 32'h0);

    // Reset discards an in-flight pending entry, even while stalled.
    rd_sel_b = 3'd4;
    drive(1'b1, 1'b1, 3'd4, 16'h4444, 1'b0);
    drive(1'b0, 1'b1, 3'd4, 16'h5555, 1'b1);
    check("rst_discard_rd", {16'd0, rd_data_b}, 32'h0);
    check("rst_discard_cnt", {24'd0, wr_count}, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    check("rst_discard_rd2", {16'd0, rd_data_b}, 32'h0);

    // Counter wrap: 256 commits to register 1.
    rd_sel_a = 3'd1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 3'd1, WIDTH'(100 + i), 1'b0);
    end
    check("wrap_255", {24'd0, wr_count}, 32'd255);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    check("wrap_0", {24'd0, wr_count}, 32'd0);
    check("wrap_reg1", {16'd0, rd_data_a}, 32'h0163);

    // Random phase.
    for (int i = 0; i < 2000; i++) begin
      rd_sel_a = 3'($urandom_range(0, 7));
      rd_sel_b = ($urandom_range(0, 3) == 0) ? rd_sel_a : 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 63) != 0),
            1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            WIDTH'($urandom),
            ($urandom_range(0, 3) == 0));
    end
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge Clock);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
